// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WR_DATA,
        RD_ISSUE,
        RD_CAPT,
        RD_DATA
    } spi_bridge_state_t;

    localparam int         CMD_RW_BIT        = 7;
    localparam logic [7:0] IDLE_FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/spi_addr_counter.sv
// Loadable incrementing address register; wrap pulses when an increment rolls all-ones over to zero.
module spi_addr_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = inc && !load && (count == '1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// Turns framed SPI bytes into register-bus read/write strobes with address auto-increment,
// returning read data through tx_data for the next byte slot.
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int               ADDR_W    = 7,
    parameter int               DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_FILL = IDLE_FILL_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ss,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_wr,
    output logic              bus_rd,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              frame_err
);

    spi_bridge_state_t state;
    spi_bridge_state_t next_state;
    logic              addr_load;
    logic              addr_inc;
    logic              addr_wrap;
    logic              wr_fire;
    logic [DATA_W-1:0] tx_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A high ss ends the frame from any state; bytes arriving with it are dropped.
    always_comb begin
        next_state = state;
        addr_load  = 1'b0;
        wr_fire    = 1'b0;
        if (ss) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:     next_state = CMD;
                CMD: begin
                    if (rx_valid) begin
                        addr_load  = 1'b1;
                        next_state = rx_data[CMD_RW_BIT] ? RD_ISSUE : WR_DATA;
                    end
                end
                WR_DATA:  wr_fire = rx_valid;
                RD_ISSUE: next_state = RD_CAPT;
                RD_CAPT:  next_state = RD_DATA;
                RD_DATA: begin
                    if (rx_valid) begin
                        next_state = RD_ISSUE;
                    end
                end
                default:  next_state = IDLE;
            endcase
        end
    end

    assign bus_rd   = (state == RD_ISSUE);
    assign addr_inc = bus_wr || (state == RD_CAPT);

    // Read data is forwarded straight through during capture so it reaches the shifter one cycle sooner.
    assign tx_data  = (state == RD_CAPT) ? bus_rdata : tx_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus_wr    <= 1'b0;
            bus_wdata <= '0;
            busy      <= 1'b0;
            tx_reg    <= IDLE_FILL;
            frame_err <= 1'b0;
        end else begin
            bus_wr <= wr_fire;
            if (wr_fire) begin
                bus_wdata <= rx_data;
            end
            busy <= (next_state == WR_DATA) || (next_state == RD_ISSUE) ||
                    (next_state == RD_CAPT) || (next_state == RD_DATA);
            if (next_state == IDLE) begin
                tx_reg <= IDLE_FILL;
            end else if (state == RD_CAPT) begin
                tx_reg <= bus_rdata;
            end
            if (addr_wrap) begin
                frame_err <= 1'b1;
            end
        end
    end

    spi_addr_counter #(
        .W(ADDR_W)
    ) u_addr_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (addr_load),
        .load_val (rx_data[ADDR_W-1:0]),
        .inc      (addr_inc),
        .count    (bus_addr),
        .wrap     (addr_wrap)
    );

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Byte-level transaction engine sitting directly downstream of the SPI slave shifter.
- Consumes received bytes (rx_data/rx_valid) framed by slave-select and turns them into register-bus read/write strobes with address auto-increment.
- Drives tx_data back into the shifter's parallel load input, so read data is returned in the next SPI byte slot.
- Frame format: byte0 = {rw, addr[6:0]}, where rw = 1 means read; every later byte is one data beat.

Parameters:
- ADDR_W, 7, register address width; must equal command-byte address field width.
- DATA_W, 8, byte/register data width.
- IDLE_FILL, 8'h00, tx_data value outside read bursts.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous reset, active-low.
- ss, in, 1, slave-select, already synchronised to clk; 1 = frame inactive.
- rx_valid, in, 1, one-cycle pulse: rx_data holds a complete received byte (shifter req, synchronised).
- rx_data, in, DATA_W, received byte.
- tx_data, out, DATA_W, byte the shifter loads at its next byte boundary.
- bus_addr, out, ADDR_W, register address.
- bus_wdata, out, DATA_W, write data.
- bus_wr, out, 1, one-cycle write strobe.
- bus_rd, out, 1, one-cycle read strobe.
- bus_rdata, in, DATA_W, read data, valid exactly 1 cycle after bus_rd.
- busy, out, 1, 1 while frame is active and past the command byte.
- frame_err, out, 1, sticky; set when a read/write burst address wraps; cleared by reset only.

Behaviour:
- Reset (rst = 0 at posedge clk): state = IDLE, tx_data = IDLE_FILL, bus_addr = 0, bus_wdata = 0, bus_wr = 0, bus_rd = 0, busy = 0, frame_err = 0.
- States: IDLE, CMD, WR_DATA, RD_ISSUE, RD_CAPT, RD_DATA.
- IDLE, ss = 1: hold; tx_data = IDLE_FILL. ss = 0 -> CMD.
- CMD, rx_valid:
  - Latch bus_addr = rx_data[ADDR_W-1:0].
  - rx_data[7] = 0 -> WR_DATA, busy = 1.
  - rx_data[7] = 1 -> RD_ISSUE.
- WR_DATA, rx_valid:
  - Next cycle: bus_wdata = rx_data, bus_wr = 1 for exactly 1 cycle at current bus_addr.
  - The cycle after the strobe, bus_addr increments modulo 2^ADDR_W.
- RD_ISSUE: bus_rd = 1 for 1 cycle -> RD_CAPT.
- RD_CAPT: tx_data = bus_rdata; bus_addr increments; -> RD_DATA; busy = 1.
- RD_DATA, rx_valid: received byte is ignored (dummy) -> RD_ISSUE for the next address.
- Read latency: rx_valid at cycle N -> bus_rd at N+1 -> tx_data updated at N+2.
- System constraint: the SPI byte period must be at least 4 clk, so tx_data is stable before the shifter's next load.
- Address wrap: an increment from all-ones to 0 sets frame_err; the burst continues at address 0.
- ss rising (frame end) in any state: next cycle -> IDLE, busy = 0, tx_data = IDLE_FILL.
  - A strobe already asserted in that cycle completes (1 cycle); no new strobe is issued.
- rx_valid and ss = 1 in the same cycle: ss wins; the byte is dropped, no strobe.
- rx_valid in RD_ISSUE or RD_CAPT (protocol overrun): byte ignored; the read sequence completes normally.
- Empty frame (ss low then high with no rx_valid): no bus activity; return to IDLE.
- bus_wr and bus_rd are never high in the same cycle.

Decomposition:
- Shared package spi_pkg:
  - State enum spi_bridge_state_t.
  - Constant CMD_RW_BIT = 7.
  - Default IDLE_FILL.
- One sub-module is natural: spi_addr_counter (loadable, incrementing address register with wrap flag), reusing the team's counter style.

Test Plan:
- Reset: rst = 0 for 2 clk -> tx_data = 8'h00, bus_wr = bus_rd = 0, busy = 0, frame_err = 0.
- Write burst: frame bytes 0x10, 0xAA, 0x55 -> bus_wr twice, (addr 0x10, 0xAA) then (addr 0x11, 0x55); ss high -> busy = 0.
- Read burst: regs[0x20] = 0x3C, regs[0x21] = 0xC3; frame bytes 0xA0, dummy, dummy -> bus_rd at 0x20 then 0x21; tx_data = 0x3C two clk after the first rx_valid, then 0xC3.
- Wrap: write frame 0x7F, 0x01, 0x02 -> writes to 0x7F then 0x00; frame_err = 1 and stays 1 through the next frame.
- Abort: read frame 0x85, then ss raised in the same cycle as the second rx_valid -> exactly one bus_rd (addr 0x05), tx_data returns to 0x00, state IDLE.
- Mid-frame reset: rst = 0 during WR_DATA -> no further bus_wr; all outputs at reset values the next cycle.
